data_mem_responder: RTL

Responder end of the processor's data-memory access path. Accepts read and write strobes from the multicycle core's controller and latches address and write data. After a programmable number of wait states it completes the access, returns read data and pulses a one-cycle `ready`. It replaces the zero-latency data memory with a storage-backed slave that exercises the controller's wait-on-memory behaviour, and it counts completed accesses for debug.

---
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Storage-backed data-memory responder for the multicycle core.
//                Accepts a read or write strobe, latches the request, waits
//                WAIT_CYCLES wait states, commits the access and pulses
//                ready (and err on a bad request) for one cycle. Completed
//                non-error accesses are counted for debug.
//  Ports       : clk, rst (async, active-high)
//                mem_read, mem_write  - request strobes
//                addr, wdata          - word address / store data
//                rdata                - registered read data (to MDR)
//                ready, err           - one-cycle completion / error pulse
//                busy                 - high whenever not IDLE
//                access_count         - completed non-error accesses (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_BITS   = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [15:0] access_count
);

    localparam int         c_DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [3:0]             r_count;
    logic [15:0]            r_addr;
    logic [15:0]            r_wdata;
    logic                   r_is_write;
    logic                   r_is_both;
    logic [15:0]            r_mem [c_DEPTH];
    logic [15:0]            r_rdata;
    logic [15:0]            r_access_count;
    logic                   r_err;

    logic                   w_req;
    logic [15:0]            w_c_addr;
    logic [15:0]            w_c_wdata;
    logic                   w_c_write;
    logic                   w_c_both;
    logic                   w_out_of_range;
    logic                   w_bad;
    logic                   w_commit;
    logic [ADDR_BITS-1:0]   w_index;

    assign w_req = mem_read | mem_write;

    // With zero wait states the access commits on the accepting edge, before
    // the request registers are loaded, so the commit path looks at the live
    // inputs while in IDLE and at the latched request otherwise.
    assign w_c_addr  = (r_state == ST_IDLE) ? addr                   : r_addr;
    assign w_c_wdata = (r_state == ST_IDLE) ? wdata                  : r_wdata;
    assign w_c_write = (r_state == ST_IDLE) ? mem_write              : r_is_write;
    assign w_c_both  = (r_state == ST_IDLE) ? (mem_read & mem_write) : r_is_both;

    assign w_out_of_range = (w_c_addr >> ADDR_BITS) != 16'd0;
    assign w_bad          = w_out_of_range | w_c_both;
    assign w_index        = w_c_addr[ADDR_BITS-1:0];
    assign w_commit       = (w_next_state == ST_RESP) && (r_state != ST_RESP);

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_count == 4'd0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, wait counter and request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= 4'd0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_is_write <= 1'b0;
            r_is_both  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr     <= addr;
                        r_wdata    <= wdata;
                        r_is_write <= mem_write;
                        r_is_both  <= mem_read & mem_write;
                        r_count    <= c_WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Commit of the access on entry to RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= 16'h0000;
            end
            r_rdata        <= 16'h0000;
            r_err          <= 1'b0;
            r_access_count <= 16'h0000;
        end else begin
            r_err <= w_commit & w_bad;
            if (w_commit) begin
                if (w_bad) begin
                    r_rdata <= 16'h0000;
                end else begin
                    if (w_c_write) begin
                        r_mem[w_index] <= w_c_wdata;
                    end else begin
                        r_rdata <= r_mem[w_index];
                    end
                    r_access_count <= r_access_count + 16'd1;
                end
            end
        end
    end

    assign ready        = (r_state == ST_RESP);
    assign busy         = (r_state != ST_IDLE);
    assign err          = r_err;
    assign rdata        = r_rdata;
    assign access_count = r_access_count;

endmodule
`default_nettype wire
